// File: rtl/mixed_package.sv
// mixed_package: shared types and constants for the mixed subsystem APB command master.
package mixed_package;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_cmd_state_e;

    localparam int DEFAULT_TIMEOUT = 256;
    localparam int RSP_CH_W        = 8;
    localparam int RSP_DATA_W      = 64;

    // Widest response record; instances narrower than this use the low bits.
    typedef struct packed {
        logic [RSP_CH_W-1:0]   ch;
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    logic            found;
    logic [CH_W-1:0] c;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: round-robin arbitrated APB3 master with wait-state timeout and tagged responses.
module apb_cmd_master
    import mixed_package::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        cmd_valid,
    output logic [NUM_CH-1:0]        cmd_ready,
    input  logic [NUM_CH-1:0]        cmd_write,
    input  logic [NUM_CH*ADDR_W-1:0] cmd_addr,
    input  logic [NUM_CH*DATA_W-1:0] cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CH_W-1:0]          rsp_ch,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic [ADDR_W-1:0]        paddr,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_cmd_state_e    state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] gnt;
    logic [CNT_W-1:0]  cnt;
    logic              timed_out;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (cmd_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign cmd_ready = (state == IDLE) ? gnt : '0;
    // A zero TIMEOUT parameter disables the abort path entirely.
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_ch      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|cmd_valid) begin
                    paddr  <= cmd_addr[gnt_idx*ADDR_W +: ADDR_W];
                    pwrite <= cmd_write[gnt_idx];
                    pwdata <= cmd_write[gnt_idx] ? cmd_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
                    rsp_ch <= gnt_idx;
                    rr_ptr <= (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
                    cnt    <= '0;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // pready takes priority over a simultaneous timeout.
                    if (pready || timed_out) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
                        rsp_err     <= pready ? pslverr : 1'b1;
                        rsp_timeout <= !pready;
                        state       <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed self-checking bench for apb_cmd_master (4 channels, TIMEOUT=8).
module tb_apb_cmd_master;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        cmd_valid = '0;
    logic [NUM_CH-1:0]        cmd_ready;
    logic [NUM_CH-1:0]        cmd_write = '0;
    logic [NUM_CH*ADDR_W-1:0] cmd_addr = '0;
    logic [NUM_CH*DATA_W-1:0] cmd_wdata = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic [1:0]               rsp_ch;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     rsp_timeout;
    logic [ADDR_W-1:0]        paddr;
    logic                     psel;
    logic                     penable;
    logic                     pwrite;
    logic [DATA_W-1:0]        pwdata;
    logic [DATA_W-1:0]        prdata = '0;
    logic                     pready = 1'b0;
    logic                     pslverr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [3:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b1000};
    logic [1:0] exp_c [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};

    apb_cmd_master #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
        end
        n_cmp++;
        if (paddr !== '0 || pwdata !== '0) begin
            n_bad++;
            $display("FAIL reset_apb_bus: paddr=%h pwdata=%h want 0/0", paddr, pwdata);
        end
        n_cmp++;
        if (rsp_rdata !== '0 || rsp_ch !== 2'd0 || cmd_ready !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: rdata=%h ch=%0d ready=%b want 0/0/0000", rsp_rdata, rsp_ch, cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        cmd_valid = 4'b0001;
        cmd_write = 4'b0001;
        cmd_addr[31:0] = 32'h10;
        cmd_wdata[31:0] = 32'hDEADBEEF;
        rsp_ready = 1'b1;
        pready = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL wr_ready: got %b want 0001", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = '0;
        n_cmp++;
        if ({psel, penable} !== 2'b10 || paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_setup: sel/en=%b addr=%h wr=%b wdata=%h want 10/10/1/deadbeef",
                     {psel, penable}, paddr, pwrite, pwdata);
        end
        pready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL wr_access: sel/en/rv=%b want 110", {psel, penable, rsp_valid});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 ||
            rsp_rdata !== '0 || psel !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rsp: rv=%b ch=%0d err=%b to=%b rdata=%h psel=%b want 1/0/0/0/0/0",
                     rsp_valid, rsp_ch, rsp_err, rsp_timeout, rsp_rdata, psel);
        end
        pready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rsp_clear: rv=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        cmd_valid = 4'b0100;
        cmd_write = 4'b0000;
        cmd_addr[95:64] = 32'h24;
        cmd_wdata[95:64] = 32'hAAAA5555;
        prdata = 32'h0;
        pready = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL rd_ready: got %b want 0100", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = '0;
        n_cmp++;
        if ({psel, penable} !== 2'b10 || paddr !== 32'h24 || pwrite !== 1'b0 || pwdata !== '0) begin
            n_bad++;
            $display("FAIL rd_setup: sel/en=%b addr=%h wr=%b wdata=%h want 10/24/0/0",
                     {psel, penable}, paddr, pwrite, pwdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (penable !== 1'b1 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rd_wait%0d: en=%b rv=%b want 1/0", i, penable, rsp_valid);
            end
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h1234;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234 || rsp_ch !== 2'd2 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_rsp: rv=%b rdata=%h ch=%0d err=%b to=%b want 1/1234/2/0/0",
                     rsp_valid, rsp_rdata, rsp_ch, rsp_err, rsp_timeout);
        end
        pready = 1'b0;
        prdata = 32'hFFFFFFFF;
        @(negedge clk);
    endtask

    task automatic test_slverr();
        cmd_valid = 4'b1000;
        cmd_write = 4'b1000;
        cmd_addr[127:96] = 32'h40;
        cmd_wdata[127:96] = 32'h77;
        pready = 1'b1;
        pslverr = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL err_ready: got %b want 1000", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_ch !== 2'd3 || rsp_rdata !== '0) begin
            n_bad++;
            $display("FAIL err_rsp: rv=%b err=%b to=%b ch=%0d rdata=%h want 1/1/0/3/0",
                     rsp_valid, rsp_err, rsp_timeout, rsp_ch, rsp_rdata);
        end
        pready = 1'b0;
        pslverr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        int last;
        last = 0;
        cmd_valid = 4'hF;
        cmd_write = 4'hF;
        pready = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (cmd_ready === 4'b0 && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            n_cmp++;
            if (cmd_ready !== exp_g[k]) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got %b want %b", k, cmd_ready, exp_g[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (cyc - last != 4) begin
                    n_bad++;
                    $display("FAIL rr_interval%0d: got %0d cycles want 4", k, cyc - last);
                end
            end
            last = cyc;
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (rsp_valid !== 1'b1 && n < 10);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_ch !== exp_c[k]) begin
                n_bad++;
                $display("FAIL rr_rsp%0d: rv=%b ch=%0d want 1/%0d", k, rsp_valid, rsp_ch, exp_c[k]);
            end
            if (k == 3) cmd_valid = 4'b1010;
            if (k == 5) cmd_valid = 4'b0000;
        end
        pready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        cmd_valid = 4'b0001;
        cmd_write = 4'b0000;
        pready = 1'b0;
        prdata = 32'hFFFFFFFF;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL to_ready: got %b want 0001", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = '0;
        n_cmp++;
        if ({psel, penable} !== 2'b10) begin
            n_bad++;
            $display("FAIL to_setup: sel/en=%b want 10", {psel, penable});
        end
        n = 0;
        @(negedge clk);
        while (penable === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != TIMEOUT) begin
            n_bad++;
            $display("FAIL to_access_len: got %0d cycles want %0d", n, TIMEOUT);
        end
        n_cmp++;
        if (psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 ||
            rsp_rdata !== '0 || rsp_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL to_rsp: psel=%b rv=%b err=%b to=%b rdata=%h ch=%0d want 0/1/1/1/0/0",
                     psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, rsp_ch);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure_reset();
        logic bad;
        cmd_valid = 4'b0110;
        cmd_write = 4'b0110;
        cmd_addr[63:32] = 32'h30;
        cmd_wdata[63:32] = 32'h55;
        pready = 1'b1;
        pslverr = 1'b0;
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_ready: got %b want 0010", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 4'b0100;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_ch !== 2'd1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 ||
                rsp_rdata !== '0 || cmd_ready !== 4'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: rv=%b ch=%0d err=%b to=%b rdata=%h ready=%b want 1/1/0/0/0/0000",
                         i, rsp_valid, rsp_ch, rsp_err, rsp_timeout, rsp_rdata, cmd_ready);
            end
            @(negedge clk);
        end
        pready = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL bp_release: rv=%b ready=%b want 0/0100", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({psel, penable} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_pre_access: sel/en=%b want 11", {psel, penable});
        end
        #2;
        rst_n = 1'b0;
        pready = 1'b1;
        #1;
        n_cmp++;
        if ({psel, penable} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_async_drop: sel/en=%b want 00", {psel, penable});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || psel !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_rsp: stray activity seen=%b want 0", bad);
        end
        pready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_timeout();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Parametrised multi-requester APB master for the mixed subsystem. It arbitrates register commands from NUM_CH internal requesters, runs each command as an APB3 SETUP/ACCESS transfer with a wait-state timeout, and returns one response per command tagged with the originating channel. It replaces the fixed single-source APB source port on the cpu block, so several agents can share one register bus.

## Interface
- NUM_CH, 4: number of requester channels (≥1).
- ADDR_W, 32: APB address width.
- DATA_W, 32: APB data width.
- TIMEOUT, 256: maximum ACCESS cycles before abort; 0 disables the timeout.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  NUM_CH  per-channel command valid.
- cmd_ready  out  NUM_CH  per-channel command accept (one-hot or zero).
- cmd_write  in  NUM_CH  1 = write, 0 = read.
- cmd_addr  in  NUM_CH*ADDR_W  packed per-channel address (channel i at [i*ADDR_W +: ADDR_W]).
- cmd_wdata  in  NUM_CH*DATA_W  packed per-channel write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_ch  out  CH_W  channel index of the response; CH_W = max(1, clog2(NUM_CH)).
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_W, psel  out  1, penable  out  1, pwrite  out  1, pwdata  out  DATA_W: APB request.
- prdata  in  DATA_W, pready  in  1, pslverr  in  1: APB completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: the round-robin arbiter selects the first channel with cmd_valid, searching from rr_ptr upward with wrap. cmd_ready[g] is asserted combinationally in IDLE only. On handshake, capture write, addr and wdata (wdata forced to 0 for reads) and g, set rr_ptr = (g+1) mod NUM_CH, then go to SETUP.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata from the captured command. Go to ACCESS.
- ACCESS: psel=1, penable=1. The timeout counter increments each cycle.
  - On pready: capture prdata (reads only; writes capture 0), set err=pslverr and timeout=0, then go to RESP.
  - If pready is still low when the counter equals TIMEOUT-1: set err=1, timeout=1, rdata=0, then go to RESP.
  - pready wins over timeout in the same cycle.
- RESP: rsp_valid=1 with rsp_ch/rdata/err/timeout held stable. On rsp_ready, go to IDLE.
- No cmd_ready is asserted outside IDLE. Exactly one command is in flight.
- Reset values: all outputs 0. State=IDLE, rr_ptr=0, counter=0.
- Reset mid-transfer: psel and penable drop asynchronously. The in-flight command is discarded and produces no response.

## Timing
- Handshake in cycle N → psel=1 in N+1, penable=1 in N+2.
- With zero wait states: rsp_valid=1 in N+3. Each wait state adds 1 cycle.
- Minimum issue interval is 4 cycles per command when rsp_ready=1.
- A timeout abort drops psel/penable in the cycle after the last ACCESS cycle. ACCESS lasts exactly TIMEOUT cycles.
- Timeout counter width: clog2(TIMEOUT+1). It clears on entry to SETUP.
- APB outputs are registered. cmd_ready is the only combinational output (it depends on cmd_valid and state).

## Structure
- Shared package (mixed_package) holds:
  - apb_cmd_state_e (IDLE/SETUP/ACCESS/RESP);
  - apb_rsp_t struct (ch, rdata, err, timeout);
  - the default TIMEOUT constant.
- Sub-module rr_arbiter (NUM_CH): inputs req vector and ptr; outputs one-hot grant and encoded index. Purely combinational; the pointer register lives in apb_cmd_master.

## Test plan
- Write, ch0, addr 0x10, data 0xDEADBEEF, pready=1 → psel in N+1, penable in N+2, rsp_valid in N+3 with rsp_ch=0, err=0, rdata=0.
- Read, ch2, addr 0x24, pready low for 3 ACCESS cycles then prdata=0x1234 → rsp_rdata=0x1234 at N+6, err=0.
- All four channels valid at once → grants in order 0,1,2,3. Then only ch1 and ch3 valid (rr_ptr=0) → ch1 is granted, then ch3.
- pslverr=1 with pready → rsp_err=1, rsp_timeout=0.
- TIMEOUT=8, pready never asserted → penable high for exactly 8 cycles, then psel=0, rsp_err=1, rsp_timeout=1, rdata=0.
- rsp_ready low for 5 cycles with ch1 pending → response fields stable and cmd_ready=0 throughout. Then assert rst_n=0 during ACCESS → psel=0 immediately and no response after release.
